// File: rtl/acc_cmd_sequencer_if.sv
// Command/result handshake between a control master and acc_cmd_sequencer.
// master drives commands and observes results; slave is the sequencer side.
interface acc_cmd_sequencer_if #(
   parameter int W    = 4,
   parameter int REPW = 4
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_op;
   logic [W-1:0]    cmd_data;
   logic [REPW-1:0] cmd_rep;
   logic            res_valid;
   logic [W-1:0]    res_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_rep,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_rep,
      output cmd_ready, res_valid, res_data
   );
endinterface

// File: rtl/acc_cmd_sequencer.sv
// Queues op/data/repeat commands and issues one accumulator op per clock; first issue two edges after accept, ready drops only when the FIFO is full or clr.
// Define ACC_SEQ_CHECK_EN to add a shadow accumulator that raises a sticky err on any result mismatch.
module acc_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int W     = 4,
   parameter int REPW  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   acc_cmd_sequencer_if.slave  host,
   output logic                en,
   output logic [1:0]          sel,
   output logic [W-1:0]        in,
   input  logic [W-1:0]        acc,
   output logic                busy,
   output logic                err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [1:0]      op;
      logic [W-1:0]    data;
      logic [REPW-1:0] rep;
   } cmd_t;

   cmd_t            mem [DEPTH];
   cmd_t            head;
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count;
   logic [REPW-1:0] rem, rem_d;
   logic            en_d;
   logic [1:0]      sel_d;
   logic [W-1:0]    in_d;
   logic            res_vld;
   logic            push, pop;

   // No write bypass: a full FIFO refuses even when a pop happens this cycle.
   assign host.cmd_ready = rst && (count != CNT_FULL) && !clr;
   assign push           = host.cmd_valid && host.cmd_ready;
   assign head           = mem[rptr];

   always_comb begin
      rem_d = rem;
      en_d  = 1'b0;
      sel_d = sel;
      in_d  = in;
      pop   = 1'b0;
      if (clr) begin
         rem_d = '0;
      end else if (rem != '0) begin
         en_d  = 1'b1;
         rem_d = rem - REPW'(1);
      end else if (count != '0) begin
         pop   = 1'b1;
         en_d  = 1'b1;
         sel_d = head.op;
         in_d  = head.data;
         rem_d = head.rep;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         rem     <= '0;
         en      <= 1'b0;
         sel     <= 2'b00;
         in      <= '0;
         res_vld <= 1'b0;
      end else begin
         rem     <= rem_d;
         en      <= en_d;
         sel     <= sel_d;
         in      <= in_d;
         res_vld <= en;
         if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + (AW+1)'(1);
               2'b01:   count <= count - (AW+1)'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= '{op: host.cmd_op, data: host.cmd_data, rep: host.cmd_rep};
   end

   // The accumulator updates on the edge that samples en, so acc is the post-op value while res_valid is high.
   assign host.res_valid = res_vld;
   assign host.res_data  = acc;
   assign busy           = (count != '0) || (rem != '0) || en;

`ifdef ACC_SEQ_CHECK_EN
   logic [W-1:0] shadow;
   logic         err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow <= '0;
         err_q  <= 1'b0;
      end else begin
         if (en) begin
            case (sel)
               2'd0:    shadow <= shadow + in;
               2'd1:    shadow <= shadow - in;
               2'd2:    shadow <= shadow ^ in;
               default: ;
            endcase
         end
         if (res_vld && (acc != shadow)) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: doc/acc_cmd_sequencer.md
Name: acc_cmd_sequencer

Overview:
- Command-side driver for the controlled accumulator: produces the accumulator's en/sel/in stream and consumes its acc output.
- Accepts op/data/repeat commands over a valid/ready handshake into a small FIFO.
- Issues one accumulator operation per clock with no bubbles, and returns each post-operation acc value as a result beat.
- Sits between a control master (bench or CPU-side logic) and the accumulator instance.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >=2
W, 4, data width of in/acc
REPW, 4, width of repeat field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (all state cleared while rst=0)
clr  in  1  synchronous flush of FIFO and issue state
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready at clk edge
cmd_op  in  2  00 add, 01 sub, 10 xor, 11 hold
cmd_data  in  W  operand
cmd_rep  in  REPW  extra repetitions; command issues cmd_rep+1 times
en  out  1  to accumulator en (registered)
sel  out  2  to accumulator sel (registered)
in  out  W  to accumulator in (registered)
acc  in  W  from accumulator acc
res_valid  out  1  result beat valid
res_data  out  W  accumulator value after the issued op
busy  out  1  FIFO non-empty, or repeats pending, or en high
err  out  1  sticky model mismatch (see Optional Feature)

Behaviour:
- Reset (rst=0, async): en=0, sel=00, in=0, res_valid=0, err=0, FIFO count=0, rem=0, cmd_ready=0. After release, cmd_ready=1.
- cmd_ready = (count<DEPTH) && !clr. No write bypass when full; a push and pop in the same cycle leave count unchanged.
- FIFO: circular, pointers wrap modulo DEPTH; order preserved.
- Issue register rem (REPW bits). At each edge, highest priority first:
  - clr=1: FIFO emptied, rem=0, en=0. Any command offered that cycle is dropped (ready=0).
  - rem!=0: en=1; sel and in hold their values; rem=rem-1.
  - FIFO non-empty: pop head; en=1, sel=op, in=data, rem=rep.
  - Otherwise: en=0; sel and in hold.
- Latency: a command accepted at edge E drives en high at the earliest after edge E+1. With rem and FIFO both pending, consecutive commands issue back to back with zero idle cycles.
- Results:
  - res_valid = en delayed one cycle (registered).
  - res_data = acc, combinational pass-through, meaningful only while res_valid=1.
  - An accumulator that updates on the edge following en yields the post-op value.
- Arithmetic belongs to the accumulator, modulo 2^W: add wraps (15+1=0), sub wraps (0-1=15), xor, hold.
- busy = (count!=0) || (rem!=0) || en.
- rst asserted mid-command: en drops immediately and the remaining repeats are lost. The accumulator must share the same reset.

Optional Feature:
- Macro ACC_SEQ_CHECK_EN.
- When defined:
  - Internal shadow register exp (W bits, reset 0) applies the same op to exp whenever en=1 at an edge.
  - On each res_valid cycle, res_data!=exp sets err.
  - err stays set until rst.
  - clr does not modify exp.
- When undefined: no shadow logic; err tied 0.

Test Plan:
- Reset, push (add,3,rep=1) -> en high 2 cycles, sel=00, in=3; res_data 3 then 6; busy falls after last res_valid; err=0.
- Push (sub,2,0), (xor,15,0), (hold,5,0) consecutively after acc=6 -> three contiguous en cycles, no bubble; res_data 4, 11, 11.
- From acc=0, push (add,15,rep=1) -> res_data 15 then 14 (wrap). Then (sub,15,0) -> 15.
- cmd_valid held with (hold,0,rep=15) every cycle from empty, DEPTH=4 -> exactly 5 accepted before cmd_ready=0; ready returns 1 the cycle after first pop following the first command's 16 issues.
- clr asserted while 3 queued and rem=7 -> next cycle en=0, busy=0, count=0; command offered during clr not accepted.
- rst pulsed low mid-repeat -> en=0 and res_valid=0 asynchronously. With ACC_SEQ_CHECK_EN, forcing acc to a wrong value on a result beat sets err=1, which persists until rst.
